// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulus counter family: direction
// constants, digit clamping and parameter legality.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MAX_DIGIT_W = 31;

  // Clamp a loaded digit into the legal range 0..radix-1.
  function automatic int unsigned clamp_digit(input int unsigned val,
                                              input int unsigned radix);
    return (val >= radix) ? (radix - 32'd1) : val;
  endfunction

  // True when radix fits in a digit of digit_w bits and is at least 2.
  function automatic bit radix_legal(input int unsigned digit_w,
                                     input int unsigned radix);
    return (digit_w >= 32'd1) && (digit_w <= MAX_DIGIT_W) &&
           (radix >= 32'd2) && (radix <= (32'd1 << digit_w));
  endfunction

endpackage : counter_pkg

// File: rtl/mod_digit.sv
// One modulo-RADIX digit of the cascaded counter. A step at RADIX-1 going up
// returns to 0; a step at 0 going down returns to RADIX-1.
module mod_digit
  import counter_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned RADIX   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_max,
  output logic               at_zero
);

  localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(RADIX - 32'd1);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;
  logic [DIGIT_W-1:0] load_clamped;

  assign load_clamped = DIGIT_W'(clamp_digit(32'(load_digit), RADIX));
  assign at_max       = (digit_q == MAX_DIGIT);
  assign at_zero      = (digit_q == '0);
  assign digit        = digit_q;

  // Next digit value: load beats step, step wraps at the digit boundaries.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_clamped;
    end else if (step) begin
      if (dir == DIR_UP) begin
        digit_d = at_max ? '0 : (digit_q + DIGIT_W'(1));
      end else begin
        digit_d = at_zero ? MAX_DIGIT : (digit_q - DIGIT_W'(1));
      end
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule : mod_digit

// File: rtl/updown_mod_counter.sv
// Multi-digit up/down modulus counter with parallel load, combinational
// terminal count and a registered wrap pulse.
// Build option: define UPDOWN_COUNTER_SAT_EN for saturating mode (count holds
// at terminal count, wrap tied low).
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned RADIX   = 10,
  parameter int unsigned DIGITS  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      dir,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_val,
  output logic [DIGITS*DIGIT_W-1:0] count,
  output logic                      tc,
  output logic                      wrap
);

  if (!radix_legal(DIGIT_W, RADIX)) begin : g_radix_illegal
    $error("updown_mod_counter: RADIX must be in 2..2**DIGIT_W");
  end

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] up_ok;
  logic [DIGITS-1:0] dn_ok;
  logic [DIGITS-1:0] step;
  logic              all_max;
  logic              all_zero;
  logic              count_step;
  logic              wrap_q;
  logic              wrap_d;

  assign all_max  = &at_max;
  assign all_zero = &at_zero;
  assign tc       = (dir == DIR_UP) ? all_max : all_zero;
  assign wrap     = wrap_q;

`ifdef UPDOWN_COUNTER_SAT_EN
  assign count_step = en & ~load & ~tc;
`else
  assign count_step = en & ~load;
`endif

  // Carry/borrow chain: a digit moves only when every lower digit is at the
  // boundary for the current direction.
  always_comb begin
    up_ok    = '0;
    dn_ok    = '0;
    up_ok[0] = 1'b1;
    dn_ok[0] = 1'b1;
    for (int k = 1; k < int'(DIGITS); k++) begin
      up_ok[k] = up_ok[k-1] & at_max[k-1];
      dn_ok[k] = dn_ok[k-1] & at_zero[k-1];
    end
  end

  // Per-digit step enables for the selected direction.
  always_comb begin
    step = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      step[k] = count_step & ((dir == DIR_UP) ? up_ok[k] : dn_ok[k]);
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    mod_digit #(
      .DIGIT_W (DIGIT_W),
      .RADIX   (RADIX)
    ) u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .step       (step[k]),
      .dir        (dir),
      .load       (load),
      .load_digit (load_val[k*DIGIT_W +: DIGIT_W]),
      .digit      (count[k*DIGIT_W +: DIGIT_W]),
      .at_max     (at_max[k]),
      .at_zero    (at_zero[k])
    );
  end

  // Wrap event: an enabled, non-load edge taken at terminal count.
  always_comb begin
    wrap_d = 1'b0;
`ifndef UPDOWN_COUNTER_SAT_EN
    wrap_d = en & ~load & tc;
`endif
  end

  // Wrap pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter, DIGITS=2, RADIX=10 (BCD).
module tb_updown_mod_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc;
  logic       wrap;

  int n_cmp;
  int n_bad;

  updown_mod_counter #(
    .DIGIT_W (4),
    .RADIX   (10),
    .DIGITS  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load a value with en low, leaving load deasserted afterwards.
  task automatic do_load(input logic [7:0] v);
    en       = 1'b0;
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; dir = 1'b1; load = 1'b0; load_val = 8'h00;
    tick();
    tick();
    n_cmp++;
    if (count !== 8'h00) begin n_bad++; $display("FAIL reset_count: got %h want 00", count); end
    n_cmp++;
    if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (count !== 8'(i)) begin n_bad++; $display("FAIL reset_count_up%0d: got %h want %h", i, count, 8'(i)); end
    end
  endtask

  task automatic test_up_wrap();
    do_load(8'h98);
    n_cmp++;
    if (count !== 8'h98) begin n_bad++; $display("FAIL up_load: got %h want 98", count); end
    en = 1'b1; dir = 1'b1;
    tick();
    n_cmp++;
    if (count !== 8'h99 || tc !== 1'b1) begin n_bad++; $display("FAIL up_at99: got %h tc=%b want 99 tc=1", count, tc); end
    tick();
    n_cmp++;
    if (count !== 8'h00 || wrap !== 1'b1) begin n_bad++; $display("FAIL up_wrap: got %h wrap=%b want 00 wrap=1", count, wrap); end
    tick();
    n_cmp++;
    if (count !== 8'h01 || wrap !== 1'b0) begin n_bad++; $display("FAIL up_after: got %h wrap=%b want 01 wrap=0", count, wrap); end
    do_load(8'h09);
    en = 1'b1;
    tick();
    n_cmp++;
    if (count !== 8'h10) begin n_bad++; $display("FAIL up_carry: got %h want 10", count); end
  endtask

  task automatic test_down_wrap();
    do_load(8'h01);
    dir = 1'b0; en = 1'b1;
    tick();
    n_cmp++;
    if (count !== 8'h00 || tc !== 1'b1) begin n_bad++; $display("FAIL dn_at00: got %h tc=%b want 00 tc=1", count, tc); end
    tick();
    n_cmp++;
    if (count !== 8'h99 || wrap !== 1'b1) begin n_bad++; $display("FAIL dn_wrap: got %h wrap=%b want 99 wrap=1", count, wrap); end
    tick();
    n_cmp++;
    if (count !== 8'h98 || wrap !== 1'b0) begin n_bad++; $display("FAIL dn_after: got %h wrap=%b want 98 wrap=0", count, wrap); end
    do_load(8'h10);
    en = 1'b1;
    tick();
    n_cmp++;
    if (count !== 8'h09) begin n_bad++; $display("FAIL dn_borrow: got %h want 09", count); end
  endtask

  task automatic test_direction();
    logic [7:0] exp_seq [7];
    exp_seq = '{8'h06, 8'h07, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04};
    do_load(8'h05);
    en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) dir = 1'b0;
      tick();
      n_cmp++;
      if (count !== exp_seq[i]) begin n_bad++; $display("FAIL dir_step%0d: got %h want %h", i, count, exp_seq[i]); end
    end
    do_load(8'h00);
    dir = 1'b0; #1;
    n_cmp++;
    if (tc !== 1'b1) begin n_bad++; $display("FAIL dir_tc00_dn: got %b want 1", tc); end
    dir = 1'b1; #1;
    n_cmp++;
    if (tc !== 1'b0) begin n_bad++; $display("FAIL dir_tc00_up: got %b want 0", tc); end
    do_load(8'h99);
    dir = 1'b1; #1;
    n_cmp++;
    if (tc !== 1'b1) begin n_bad++; $display("FAIL dir_tc99_up: got %b want 1", tc); end
    dir = 1'b0; #1;
    n_cmp++;
    if (tc !== 1'b0) begin n_bad++; $display("FAIL dir_tc99_dn: got %b want 0", tc); end
  endtask

  task automatic test_load_priority();
    do_load(8'h99);
    dir = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'hC3;
    tick();
    load = 1'b0; en = 1'b0;
    n_cmp++;
    if (count !== 8'h93) begin n_bad++; $display("FAIL ld_clamp: got %h want 93", count); end
    n_cmp++;
    if (wrap !== 1'b0) begin n_bad++; $display("FAIL ld_nowrap: got %b want 0", wrap); end
    do_load(8'hFA);
    n_cmp++;
    if (count !== 8'h99) begin n_bad++; $display("FAIL ld_clamp_both: got %h want 99", count); end
  endtask

  task automatic test_hold();
    do_load(8'h99);
    en = 1'b1; dir = 1'b1;
    tick();
    en = 1'b0;
    tick();
    n_cmp++;
    if (count !== 8'h00 || wrap !== 1'b0) begin n_bad++; $display("FAIL hold: got %h wrap=%b want 00 wrap=0", count, wrap); end
    tick();
    n_cmp++;
    if (count !== 8'h00) begin n_bad++; $display("FAIL hold2: got %h want 00", count); end
  endtask

  task automatic test_async_reset();
    do_load(8'h46);
    en = 1'b1; dir = 1'b1;
    tick();
    n_cmp++;
    if (count !== 8'h47) begin n_bad++; $display("FAIL ar_pre: got %h want 47", count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (count !== 8'h00 || wrap !== 1'b0) begin n_bad++; $display("FAIL ar_immediate: got %h wrap=%b want 00 wrap=0", count, wrap); end
    tick();
    n_cmp++;
    if (count !== 8'h00) begin n_bad++; $display("FAIL ar_held: got %h want 00", count); end
    en = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

`ifdef UPDOWN_COUNTER_SAT_EN
  task automatic test_saturate();
    do_load(8'h98);
    en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (count !== 8'h99 || wrap !== 1'b0) begin n_bad++; $display("FAIL sat%0d: got %h wrap=%b want 99 wrap=0", i, count, wrap); end
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
`ifdef UPDOWN_COUNTER_SAT_EN
    test_saturate();
`else
    test_up_wrap();
    test_down_wrap();
    test_hold();
`endif
    test_direction();
    test_load_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_updown_mod_counter
